expr_sched: RTL and testbench

//   Shares one expression-checker core (8-bit char in, async clr, 1-bit accept out)

---
 rtl/expr_sched_if.sv | 44 ++++
 rtl/expr_sched.sv | 164 ++++++++++++++++
 tb/tb_expr_sched.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/expr_sched_if.sv
// rtl/expr_sched_if.sv - requester, checker and result signals of the shared expression checker
interface expr_sched_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;

    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;

    logic [7:0] chk_in;
    logic       chk_clr;
    logic       chk_out;

    logic       res_valid;
    logic       res_id;
    logic       res_ok;
    logic       res_ovf;
    logic       res_ready;

    modport slave (
        input  req0_valid, req0_data, req0_last,
        output req0_ready,
        input  req1_valid, req1_data, req1_last,
        output req1_ready,
        output chk_in, chk_clr,
        input  chk_out,
        output res_valid, res_id, res_ok, res_ovf,
        input  res_ready
    );

    modport master (
        output req0_valid, req0_data, req0_last,
        input  req0_ready,
        output req1_valid, req1_data, req1_last,
        input  req1_ready,
        input  chk_in, chk_clr,
        output chk_out,
        input  res_valid, res_id, res_ok, res_ovf,
        output res_ready
    );
endinterface

// File: rtl/expr_sched.sv
// rtl/expr_sched.sv - two-requester scheduler that buffers a string and replays it into a shared checker
module expr_sched #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        clr,
    expr_sched_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          rr_q, rr_d;
    logic          ovf_q, ovf_d;
    logic          done_first_q, done_first_d;
    logic          res_ok_q, res_ok_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    buf_q [DEPTH];
    logic          buf_we;

    logic          acc_valid;
    logic          acc_last;
    logic [7:0]    acc_data;
    logic          last_rd;
    logic          verdict;

    // Only the granted requester's channel is ever looked at.
    assign acc_valid = gnt_q ? bus.req1_valid : bus.req0_valid;
    assign acc_last  = gnt_q ? bus.req1_last  : bus.req0_last;
    assign acc_data  = gnt_q ? bus.req1_data  : bus.req0_data;

    assign last_rd = ({1'b0, rd_ptr_q} == (count_q - CNT_ONE));
    assign verdict = bus.chk_out & ~ovf_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= S_IDLE;
            gnt_q        <= 1'b0;
            rr_q         <= 1'b0;
            ovf_q        <= 1'b0;
            done_first_q <= 1'b0;
            res_ok_q     <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rr_q         <= rr_d;
            ovf_q        <= ovf_d;
            done_first_q <= done_first_d;
            res_ok_q     <= res_ok_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[wr_ptr_q] <= acc_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        rr_d         = rr_q;
        ovf_d        = ovf_q;
        done_first_d = 1'b0;
        res_ok_d     = res_ok_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        buf_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    gnt_d   = rr_q;
                    rr_d    = ~rr_q;
                    state_d = S_LOAD;
                end else if (bus.req0_valid) begin
                    gnt_d   = 1'b0;
                    state_d = S_LOAD;
                end else if (bus.req1_valid) begin
                    gnt_d   = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (acc_valid) begin
                    // Chars beyond DEPTH are swallowed so the requester can still finish its string.
                    if (count_q == FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        buf_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        count_d  = count_q + CNT_ONE;
                    end
                    if (acc_last) begin
                        if (ovf_d) begin
                            state_d      = S_DONE;
                            done_first_d = 1'b1;
                        end else begin
                            state_d = S_CLEAR;
                        end
                    end
                end
            end
            S_CLEAR: begin
                rd_ptr_d = '0;
                state_d  = S_RUN;
            end
            S_RUN: begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                if (last_rd) begin
                    state_d      = S_DONE;
                    done_first_d = 1'b1;
                end
            end
            S_DONE: begin
                // The checker flag settles on the first DONE cycle; freeze it there.
                if (done_first_q) begin
                    res_ok_d = verdict;
                end
                if (bus.res_ready) begin
                    ovf_d    = 1'b0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.req0_ready = (state_q == S_LOAD) && !gnt_q;
    assign bus.req1_ready = (state_q == S_LOAD) &&  gnt_q;

    assign bus.chk_clr = (state_q == S_CLEAR);
    assign bus.chk_in  = (state_q == S_RUN) ? buf_q[rd_ptr_q] : 8'h00;

    assign bus.res_valid = (state_q == S_DONE);
    assign bus.res_id    = (state_q == S_DONE) && gnt_q;
    assign bus.res_ovf   = (state_q == S_DONE) && ovf_q;
    assign bus.res_ok    = (state_q == S_DONE) && (done_first_q ? verdict : res_ok_q);
endmodule

// File: tb/tb_expr_sched.sv
// tb/tb_expr_sched.sv - randomized self-checking bench for expr_sched with a string-level reference model
module tb_expr_sched;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    expr_sched_if bus();

    expr_sched #(.DEPTH(16), .AW(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    int               cyc = 0;
    logic [7:0]       chk_seen[$];
    int               chk_cyc[$];
    logic [2:0]       res_q[$];
    int               res_rd = 0;
    int               clr_pulses = 0;
    int               both_ready = 0;
    int               res_rise_cyc = 0;
    logic             res_valid_prev = 1'b0;

    function automatic bit is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic bit is_op(input logic [7:0] c);
        return (c == 8'h2B) || (c == 8'h2D) || (c == 8'h2A) || (c == 8'h2F);
    endfunction

    // Stand-in checker core: single digits separated by binary operators.
    int ck_st = 0;
    function automatic int ck_step(input int st, input logic [7:0] c);
        if (st == 0) return is_digit(c) ? 1 : 2;
        if (st == 1) return is_op(c) ? 0 : 2;
        return 2;
    endfunction

    always @(posedge clk or posedge bus.chk_clr) begin
        if (bus.chk_clr) ck_st <= 0;
        else if (bus.chk_in != 8'h00) ck_st <= ck_step(ck_st, bus.chk_in);
    end
    assign bus.chk_out = (ck_st == 1);

    function automatic bit model_ovf(input string s);
        return s.len() > DEPTH;
    endfunction

    function automatic bit model_ok(input string s);
        if (s.len() == 0 || s.len() > DEPTH || (s.len() % 2) == 0) return 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            if ((i % 2) == 0 ? !is_digit(s[i]) : !is_op(s[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.chk_in != 8'h00) begin
            chk_seen.push_back(bus.chk_in);
            chk_cyc.push_back(cyc);
        end
        if (bus.chk_clr) clr_pulses <= clr_pulses + 1;
        if (bus.req0_ready && bus.req1_ready) both_ready <= both_ready + 1;
        if (bus.res_valid && !res_valid_prev) res_rise_cyc <= cyc;
        res_valid_prev <= bus.res_valid;
        if (bus.res_valid && bus.res_ready) res_q.push_back({bus.res_id, bus.res_ok, bus.res_ovf});
    end

    function automatic string add_char(input string s, input logic [7:0] c);
        string t;
        t = {s, " "};
        t.putc(s.len(), c);
        return t;
    endfunction

    function automatic string chain(input int n);
        string s = "";
        for (int i = 0; i < n; i++) s = add_char(s, (i % 2 == 0) ? 8'h31 : 8'h2B);
        return s;
    endfunction

    function automatic string rand_str();
        string s = "";
        string digits = "0123456789";
        string ops = "+-*/";
        string junk = "()x=";
        int len;
        logic [7:0] c;
        len = $urandom_range(1, 20);
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 9) == 0) c = junk[$urandom_range(0, 3)];
            else if (i % 2 == 0) c = digits[$urandom_range(0, 9)];
            else c = ops[$urandom_range(0, 3)];
            s = add_char(s, c);
        end
        return s;
    endfunction

    task automatic set_req(input int id, input logic v, input logic [7:0] d, input logic l);
        if (id == 1) begin
            bus.req1_valid = v; bus.req1_data = d; bus.req1_last = l;
        end else begin
            bus.req0_valid = v; bus.req0_data = d; bus.req0_last = l;
        end
    endtask

    task automatic drive(input int id, input string s);
        bit   acc;
        int   n;
        logic rdy;
        for (int i = 0; i < s.len(); i++) begin
            acc = 1'b0;
            n = 0;
            set_req(id, 1'b1, s[i], i == s.len() - 1);
            while (!acc && n < 400) begin
                @(negedge clk);
                rdy = (id == 1) ? bus.req1_ready : bus.req0_ready;
                @(posedge clk); #1;
                acc = rdy;
                n++;
            end
            if (!acc) begin
                vectors++;
                miscompares++;
                $display("FAIL drive_timeout req%0d char %0d: ready stayed 0, required 1", id, i);
                set_req(id, 1'b0, 8'h00, 1'b0);
                return;
            end
        end
        set_req(id, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic get_res(output logic [2:0] r);
        int n = 0;
        r = 3'bxxx;
        while (res_q.size() <= res_rd && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (res_q.size() > res_rd) begin
            r = res_q[res_rd];
            res_rd++;
        end else begin
            miscompares++;
            $display("FAIL res_timeout: no result after %0d cycles, required one", n);
        end
    endtask

    task automatic test_reset();
        logic [15:0] outs;
        bus.res_ready = 1'b1;
        set_req(0, 1'b1, 8'h31, 1'b1);
        set_req(1, 1'b1, 8'h32, 1'b1);
        #1 clr = 1'b1;
        #1;
        outs = {bus.req0_ready, bus.req1_ready, bus.chk_in, bus.chk_clr,
                bus.res_valid, bus.res_id, bus.res_ok, bus.res_ovf};
        vectors++;
        if (outs !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required 0000", outs);
        end
        repeat (3) @(posedge clk);
        #1;
        outs = {bus.req0_ready, bus.req1_ready, bus.chk_in, bus.chk_clr,
                bus.res_valid, bus.res_id, bus.res_ok, bus.res_ovf};
        vectors++;
        if (outs !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_held: got %h, required 0000", outs);
        end
        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        clr = 1'b0;
    endtask

    task automatic test_basic();
        string s = "1+2";
        logic [2:0] r;
        int c0, ch0, cp0;
        c0 = cyc; ch0 = chk_seen.size(); cp0 = clr_pulses;
        drive(0, s);
        get_res(r);
        vectors++;
        if (r !== {1'b0, model_ok(s), model_ovf(s)}) begin
            miscompares++;
            $display("FAIL basic_result: got %b, required %b", r, {1'b0, model_ok(s), model_ovf(s)});
        end
        vectors++;
        if (clr_pulses - cp0 != 1) begin
            miscompares++;
            $display("FAIL basic_clr_pulses: got %0d, required 1", clr_pulses - cp0);
        end
        vectors++;
        if (chk_seen.size() - ch0 != 3) begin
            miscompares++;
            $display("FAIL basic_chk_count: got %0d, required 3", chk_seen.size() - ch0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (chk_seen[ch0 + i] !== s[i] || chk_cyc[ch0 + i] != chk_cyc[ch0] + i) begin
                    miscompares++;
                    $display("FAIL basic_chk_in[%0d]: got %h at +%0d, required %h at +%0d",
                             i, chk_seen[ch0 + i], chk_cyc[ch0 + i] - chk_cyc[ch0], s[i], i);
                end
            end
        end
        vectors++;
        if (res_rise_cyc - c0 != 1 + 3 + 1 + 3) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d cycles, required 8", res_rise_cyc - c0);
        end
    endtask

    task automatic test_reject();
        string s0 = "12";
        string s1 = "1+";
        logic [2:0] r;
        drive(1, s0);
        drive(1, s1);
        get_res(r);
        vectors++;
        if (r !== {1'b1, model_ok(s0), model_ovf(s0)}) begin
            miscompares++;
            $display("FAIL reject_12: got %b, required %b", r, {1'b1, model_ok(s0), model_ovf(s0)});
        end
        get_res(r);
        vectors++;
        if (r !== {1'b1, model_ok(s1), model_ovf(s1)}) begin
            miscompares++;
            $display("FAIL reject_1plus: got %b, required %b", r, {1'b1, model_ok(s1), model_ovf(s1)});
        end
    endtask

    task automatic test_round_robin();
        string exp_s[4] = '{"1+2", "9-8", "3*4", "7"};
        int    exp_id[4] = '{0, 1, 0, 1};
        logic [2:0] r;
        int br0;
        test_reset();
        br0 = both_ready;
        fork
            begin drive(0, exp_s[0]); drive(0, exp_s[2]); end
            begin drive(1, exp_s[1]); drive(1, exp_s[3]); end
        join
        for (int i = 0; i < 4; i++) begin
            get_res(r);
            vectors++;
            if (r !== {exp_id[i][0], model_ok(exp_s[i]), model_ovf(exp_s[i])}) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: got %b, required %b", i, r,
                         {exp_id[i][0], model_ok(exp_s[i]), model_ovf(exp_s[i])});
            end
        end
        vectors++;
        if (both_ready != br0) begin
            miscompares++;
            $display("FAIL rr_exclusive_ready: got %0d cycles with both ready, required 0", both_ready - br0);
        end
    endtask

    task automatic test_overflow();
        int lens[3] = '{17, 16, 15};
        string s;
        logic [2:0] r;
        int ch0, cp0;
        for (int k = 0; k < 3; k++) begin
            s = chain(lens[k]);
            ch0 = chk_seen.size(); cp0 = clr_pulses;
            drive(0, s);
            get_res(r);
            vectors++;
            if (r !== {1'b0, model_ok(s), model_ovf(s)}) begin
                miscompares++;
                $display("FAIL ovf_len%0d: got %b, required %b", lens[k], r, {1'b0, model_ok(s), model_ovf(s)});
            end
            vectors++;
            if (clr_pulses - cp0 != (model_ovf(s) ? 0 : 1) ||
                chk_seen.size() - ch0 != (model_ovf(s) ? 0 : s.len())) begin
                miscompares++;
                $display("FAIL ovf_len%0d_replay: got %0d clr %0d chars, required %0d clr %0d chars",
                         lens[k], clr_pulses - cp0, chk_seen.size() - ch0,
                         model_ovf(s) ? 0 : 1, model_ovf(s) ? 0 : s.len());
            end
        end
    endtask

    task automatic test_clr_mid_run();
        string s = "5*7";
        logic [2:0] r;
        logic [15:0] outs;
        bit seen = 1'b0;
        int nres;
        drive(0, chain(15));
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.chk_in != 8'h00);
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL clr_mid_run_start: RUN not reached, required chk_in activity");
        end
        repeat (3) @(negedge clk);
        nres = res_q.size();
        clr = 1'b1;
        #1;
        outs = {bus.req0_ready, bus.req1_ready, bus.chk_in, bus.chk_clr,
                bus.res_valid, bus.res_id, bus.res_ok, bus.res_ovf};
        vectors++;
        if (outs !== 16'h0000) begin
            miscompares++;
            $display("FAIL clr_mid_run_outputs: got %h, required 0000", outs);
        end
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (25) begin @(posedge clk); #1; end
        vectors++;
        if (res_q.size() != nres) begin
            miscompares++;
            $display("FAIL clr_mid_run_discard: got %0d results, required 0", res_q.size() - nres);
        end
        drive(0, s);
        get_res(r);
        vectors++;
        if (r !== {1'b0, model_ok(s), model_ovf(s)}) begin
            miscompares++;
            $display("FAIL clr_resend: got %b, required %b", r, {1'b0, model_ok(s), model_ovf(s)});
        end
    endtask

    task automatic test_stall();
        string s0 = "1+2";
        string s1 = "4/2";
        logic [2:0] r;
        logic [4:0] obs;
        logic [4:0] exp;
        bit seen = 1'b0;
        bus.res_ready = 1'b0;
        drive(0, s0);
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = bus.res_valid;
        end
        @(posedge clk); #1;
        exp = {1'b1, 1'b0, model_ok(s0), model_ovf(s0), 1'b0};
        fork
            drive(1, s1);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    obs = {bus.res_valid, bus.res_id, bus.res_ok, bus.res_ovf, bus.req1_ready};
                    vectors++;
                    if (obs !== exp) begin
                        miscompares++;
                        $display("FAIL stall_cycle%0d: got %b, required %b", i, obs, exp);
                    end
                end
                @(posedge clk); #1;
                bus.res_ready = 1'b1;
            end
        join
        get_res(r);
        vectors++;
        if (r !== {1'b0, model_ok(s0), model_ovf(s0)}) begin
            miscompares++;
            $display("FAIL stall_first: got %b, required %b", r, {1'b0, model_ok(s0), model_ovf(s0)});
        end
        get_res(r);
        vectors++;
        if (r !== {1'b1, model_ok(s1), model_ovf(s1)}) begin
            miscompares++;
            $display("FAIL stall_release: got %b, required %b", r, {1'b1, model_ok(s1), model_ovf(s1)});
        end
    endtask

    task automatic test_random();
        string s;
        int id, ch0;
        logic [2:0] r;
        for (int k = 0; k < 24; k++) begin
            s = rand_str();
            id = $urandom_range(0, 1);
            ch0 = chk_seen.size();
            drive(id, s);
            get_res(r);
            vectors++;
            if (r !== {id[0], model_ok(s), model_ovf(s)}) begin
                miscompares++;
                $display("FAIL random%0d \"%s\": got %b, required %b", k, s, r, {id[0], model_ok(s), model_ovf(s)});
            end
            vectors++;
            if (chk_seen.size() - ch0 != (model_ovf(s) ? 0 : s.len())) begin
                miscompares++;
                $display("FAIL random%0d_replay: got %0d chars, required %0d",
                         k, chk_seen.size() - ch0, model_ovf(s) ? 0 : s.len());
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        bus.res_ready = 1'b1;
        test_reset();
        test_basic();
        test_reject();
        test_round_robin();
        test_overflow();
        test_clr_mid_run();
        test_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
